// File: rtl/bus_transfer_sequencer.sv
// bus_transfer_sequencer: queued register-to-register bus transfers, drive then latch
module bus_transfer_sequencer #(
    parameter int DEPTH   = 4,
    parameter int NUM_SRC = 24
) (
    input  logic                   clk,
    input  logic                   clr_n,
    input  logic                   req_valid,
    input  logic [4:0]             req_src,
    input  logic [4:0]             req_dst,
    output logic                   req_ready,
    output logic [31:0]            out_en,
    output logic [31:0]            in_en,
    output logic                   done,
    output logic                   err,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] fifo_count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, DRIVE, LATCH} state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [4:0]      cur_src_q, cur_src_d, cur_dst_q, cur_dst_d;
    logic [31:0]     out_en_q, out_en_d, in_en_q, in_en_d;
    logic            done_q, done_d, err_q, err_d;
    logic            accept, legal, push, pop;
    logic [4:0]      src_mem [DEPTH];
    logic [4:0]      dst_mem [DEPTH];

    assign req_ready  = count_q != CW'(DEPTH);
    assign out_en     = out_en_q;
    assign in_en      = in_en_q;
    assign done       = done_q;
    assign err        = err_q;
    assign fifo_count = count_q;
    assign busy       = (state_q != IDLE) || (count_q != '0);

    // Next-state: FIFO bookkeeping, pop decision in IDLE/LATCH, registered outputs for the coming state
    always_comb begin
        accept    = req_valid && req_ready;
        legal     = 32'(req_src) < NUM_SRC;
        push      = accept && legal;
        pop       = (state_q != DRIVE) && (count_q != '0);
        err_d     = accept && !legal;
        wr_ptr_d  = wr_ptr_q + PW'(push);
        rd_ptr_d  = rd_ptr_q + PW'(pop);
        count_d   = count_q + CW'(push) - CW'(pop);
        state_d   = IDLE;
        cur_src_d = cur_src_q;
        cur_dst_d = cur_dst_q;
        out_en_d  = '0;
        in_en_d   = '0;
        done_d    = 1'b0;
        if (pop) begin
            state_d   = DRIVE;
            cur_src_d = src_mem[rd_ptr_q];
            cur_dst_d = dst_mem[rd_ptr_q];
            out_en_d  = 32'd1 << src_mem[rd_ptr_q];
        end else if (state_q == DRIVE) begin
            state_d  = LATCH;
            out_en_d = 32'd1 << cur_src_q;
            in_en_d  = 32'd1 << cur_dst_q;
            done_d   = 1'b1;
        end
    end

    // State, pointers and registered outputs; reset aborts any transfer and empties the queue
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q   <= IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            cur_src_q <= '0;
            cur_dst_q <= '0;
            out_en_q  <= '0;
            in_en_q   <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            cur_src_q <= cur_src_d;
            cur_dst_q <= cur_dst_d;
            out_en_q  <= out_en_d;
            in_en_q   <= in_en_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    // Request storage; contents are only read while count is non-zero, so no reset needed
    always_ff @(posedge clk) begin
        if (push) begin
            src_mem[wr_ptr_q] <= req_src;
            dst_mem[wr_ptr_q] <= req_dst;
        end
    end
endmodule
